// File: rtl/mc_request_queue_if.sv
// rtl/mc_request_queue_if.sv - parser-side and scheduler-side signal bundle for mc_request_queue
interface mc_request_queue_if #(
  parameter int DEPTH  = 16,
  parameter int TIME_W = 12,
  parameter int CMD_W  = 12,
  parameter int ADDR_W = 36
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                            data_rdy;
  logic [TIME_W+CMD_W+ADDR_W-1:0]  data_read;
  logic                            data_req;
  logic                            shutdown;
  logic                            out_valid;
  logic                            out_ready;
  logic [1:0]                      out_cmd;
  logic [15:0]                     out_row;
  logic [1:0]                      out_bg;
  logic [1:0]                      out_bank;
  logic [10:0]                     out_col;
  logic [TIME_W-1:0]               out_time;
  logic [CNT_W-1:0]                count;
  logic                            full;
  logic                            empty;
  logic                            err_cmd;
  logic                            overflow;
  logic                            drained;

  modport master (
    output data_rdy, data_read, shutdown, out_ready,
    input  data_req, out_valid, out_cmd, out_row, out_bg, out_bank, out_col, out_time,
    input  count, full, empty, err_cmd, overflow, drained
  );

  modport slave (
    input  data_rdy, data_read, shutdown, out_ready,
    output data_req, out_valid, out_cmd, out_row, out_bg, out_bank, out_col, out_time,
    output count, full, empty, err_cmd, overflow, drained
  );
endinterface

// File: rtl/mc_request_queue.sv
// rtl/mc_request_queue.sv - time-gated trace request FIFO with DDR4 address decode
module mc_request_queue #(
  parameter int DEPTH   = 16,
  parameter int TIME_W  = 12,
  parameter int CMD_W   = 12,
  parameter int ADDR_W  = 36,
  parameter int CYCLE_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CYCLE_W-1:0] cycle,
  mc_request_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Only addr[33:3] is kept; the top two bits and the byte select never leave the queue.
  localparam int KEEP_W = 31;
  localparam int ENT_W  = TIME_W + 2 + KEEP_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next;
  logic              data_req_r;
  logic              err_r;
  logic              ovf_r;
  logic              drained_r;
  logic              shut_seen;

  logic              full_w;
  logic              empty_w;
  logic              cmd_ok;
  logic              enq;
  logic              deq;
  logic              valid_w;

  logic [ENT_W-1:0]  head_ent;
  logic [TIME_W-1:0] head_time;
  logic [1:0]        head_cmd;
  logic [KEEP_W-1:0] head_addr;

  logic [TIME_W-1:0] in_time;
  logic [CMD_W-1:0]  in_cmd;
  logic [KEEP_W-1:0] in_addr;

  assign in_time = bus.data_read[TIME_W+CMD_W+ADDR_W-1 -: TIME_W];
  assign in_cmd  = bus.data_read[CMD_W+ADDR_W-1 -: CMD_W];
  assign in_addr = bus.data_read[33:3];

  assign full_w  = (count_r == CNT_W'(DEPTH));
  assign empty_w = (count_r == '0);
  assign cmd_ok  = (in_cmd <= CMD_W'(2));

  assign head_ent  = mem[head];
  assign head_time = head_ent[ENT_W-1 -: TIME_W];
  assign head_cmd  = head_ent[KEEP_W+1 -: 2];
  assign head_addr = head_ent[KEEP_W-1:0];

  assign valid_w = !empty_w && (cycle >= {{(CYCLE_W-TIME_W){1'b0}}, head_time});
  assign deq     = valid_w && bus.out_ready;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign enq     = bus.data_rdy && cmd_ok && (!full_w || deq);

  assign count_next = count_r + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, deq};

  always_ff @(posedge clock) begin
    if (enq) begin
      mem[tail] <= {in_time, in_cmd[1:0], in_addr};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count_r    <= '0;
      data_req_r <= 1'b0;
      err_r      <= 1'b0;
      ovf_r      <= 1'b0;
      drained_r  <= 1'b0;
      shut_seen  <= 1'b0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count_r    <= count_next;
      data_req_r <= (count_next <= CNT_W'(DEPTH-2)) && !bus.shutdown;
      err_r      <= bus.data_rdy && !cmd_ok;
      ovf_r      <= bus.data_rdy && cmd_ok && full_w && !deq;
      shut_seen  <= shut_seen || bus.shutdown;
      drained_r  <= (shut_seen || bus.shutdown) && empty_w;
    end
  end

  // head_addr holds addr[33:3], so addr[n] sits at head_addr[n-3].
  always_comb begin
    bus.out_cmd  = '0;
    bus.out_row  = '0;
    bus.out_bg   = '0;
    bus.out_bank = '0;
    bus.out_col  = '0;
    bus.out_time = '0;
    if (!empty_w) begin
      bus.out_cmd  = head_cmd;
      bus.out_row  = head_addr[30:15];
      bus.out_bank = head_addr[6:5];
      bus.out_bg   = head_addr[4:3];
      bus.out_col  = {head_addr[14:7], head_addr[2:0]};
      bus.out_time = head_time;
    end
  end

  assign bus.out_valid = valid_w;
  assign bus.data_req  = data_req_r;
  assign bus.count     = count_r;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.err_cmd   = err_r;
  assign bus.overflow  = ovf_r;
  assign bus.drained   = drained_r;
endmodule
